// File: rtl/regfile_mp_pkg.sv
// regfile_mp shared types and defaults.
// FSM state encoding and default geometry.
package regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp bus: read ports, write, reserve, clear.
// master drives requests, slave is the register file.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ready;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     clr_req;
  logic                     busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_pend, wr_ready, busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr, clr_req,
    output rd_data, rd_pend, wr_ready, busy
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write bit per entry.
// set beats clear on the same entry; flush wipes all.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        look_pend
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_q;

  // pending bits: clear then set so a new producer wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else if (flush) begin
      pend_q <= '0;
    end else begin
      if (clr_en) pend_q[clr_addr] <= 1'b0;
      if (set_en) pend_q[set_addr] <= 1'b1;
    end
  end

  // per-port lookup
  always_comb begin
    look_pend = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      look_pend[k] = pend_q[look_addr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending bits,
// write bypass and a zeroing sweep on reset/clear.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic        clk,
  input logic        reset_n,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              busy;
  logic              wr_acc;
  logic              rsv_acc;
  logic [NUM_RD-1:0] sb_pend;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign busy         = (state == SWEEP);
  assign bus.busy     = busy;
  assign bus.wr_ready = ~busy;

  assign wr_acc  = bus.wr_en & ~busy &
                   ~is_zero(bus.wr_addr);
  assign rsv_acc = bus.rsv_en & ~busy &
                   ~is_zero(bus.rsv_addr);

  // sweep FSM: ptr walks 0..DEPTH-1, clr_req restarts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= SWEEP;
            ptr   <= '0;
          end
        end
        SWEEP: begin
          if (bus.clr_req) begin
            ptr <= '0;
          end else if (ptr == LAST) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= SWEEP;
          ptr   <= '0;
        end
      endcase
    end
  end

  // storage: sweep zeroes, otherwise accepted writes
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_mp_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (busy),
    .set_en    (rsv_acc),
    .set_addr  (bus.rsv_addr),
    .clr_en    (wr_acc),
    .clr_addr  (bus.wr_addr),
    .look_addr (bus.rd_addr),
    .look_pend (sb_pend)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic              mask;

    assign ra   = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = wr_acc & (bus.wr_addr == ra);
    assign mask = busy | is_zero(ra);

    assign bus.rd_data[k*DATA_W +: DATA_W] =
      mask ? '0 :
      hit  ? bus.wr_data : mem[ra];
    assign bus.rd_pend[k] =
      ~mask & ~hit & sb_pend[k];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed vectors,
// behavioural model checked every negedge.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  int checks = 0;
  int errors = 0;

  regfile_mp_if #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR)
  ) bus ();

  regfile_mp #(
    .DATA_W (DW), .ADDR_W (AW),
    .NUM_RD (NR), .ZERO_REG (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // behavioural model
  logic [31:0] m_mem [DEPTH];
  bit          m_pend [DEPTH];
  int          m_sweep = DEPTH;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sweep = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
    end else begin
      if (m_sweep == 0) begin
        if (bus.wr_en && bus.wr_addr != 0) begin
          m_mem[bus.wr_addr]  = bus.wr_data;
          m_pend[bus.wr_addr] = 1'b0;
        end
        if (bus.rsv_en && bus.rsv_addr != 0)
          m_pend[bus.rsv_addr] = 1'b1;
      end else begin
        m_sweep--;
        if (m_sweep == 0)
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
      if (bus.clr_req) begin
        m_sweep = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
      end
    end
  end

  // compare DUT against model every cycle
  always @(negedge clk) begin
    logic        m_busy;
    logic [3:0]  a;
    logic [31:0] ed;
    logic        ep;
    m_busy = (m_sweep != 0);
    chk("cmp_busy", 32'(bus.busy), 32'(m_busy));
    chk("cmp_wr_ready", 32'(bus.wr_ready), 32'(!m_busy));
    for (int k = 0; k < NR; k++) begin
      a  = bus.rd_addr[k*AW +: AW];
      ed = '0;
      ep = 1'b0;
      if (!m_busy && a != 0) begin
        if (bus.wr_en && bus.wr_addr == a) begin
          ed = bus.wr_data;
        end else begin
          ed = m_mem[a];
          ep = m_pend[a];
        end
      end
      chk($sformatf("cmp_rd_data%0d", k),
          bus.rd_data[k*DW +: DW], ed);
      chk($sformatf("cmp_rd_pend%0d", k),
          32'(bus.rd_pend[k]), 32'(ep));
    end
  end

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {4'(a1), 4'(a0)};
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rdd(input int k);
    return bus.rd_data[k*DW +: DW];
  endfunction

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    chk(nm, n, 16);
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < DEPTH; a++) begin
      tick();
      set_rd(a, DEPTH - 1 - a);
      @(negedge clk);
      chk({nm, "_p0"}, rdd(0), 32'h0);
      chk({nm, "_p1"}, rdd(1), 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.clr_req  = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    count_busy("rst_busy_len");
    read_all_zero("rst_zero");

    // write bypass then storage
    tick();
    wr(5, 32'hDEADBEEF);
    set_rd(5, 0);
    @(negedge clk);
    chk("byp_r5", rdd(0), 32'hDEADBEEF);
    chk("byp_r5_pend", 32'(bus.rd_pend[0]), 32'd0);
    tick();
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("mem_r5", rdd(0), 32'hDEADBEEF);

    // reserve r7, then fill it
    tick();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 4'd7;
    set_rd(7, 7);
    @(negedge clk);
    chk("rsv_r7_early", 32'(bus.rd_pend[0]), 32'd0);
    tick();
    bus.rsv_en = 1'b0;
    @(negedge clk);
    chk("rsv_r7_p0", 32'(bus.rd_pend[0]), 32'd1);
    chk("rsv_r7_p1", 32'(bus.rd_pend[1]), 32'd1);
    tick();
    wr(7, 32'h12);
    @(negedge clk);
    chk("byp_r7", rdd(0), 32'h12);
    chk("byp_r7_pend", 32'(bus.rd_pend[0]), 32'd0);
    tick();
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("mem_r7", rdd(1), 32'h12);
    chk("mem_r7_pend", 32'(bus.rd_pend[1]), 32'd0);

    // reserve and write r3 in the same cycle
    tick();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 4'd3;
    wr(3, 32'h55);
    set_rd(3, 3);
    @(negedge clk);
    chk("byp_r3", rdd(0), 32'h55);
    chk("byp_r3_pend", 32'(bus.rd_pend[0]), 32'd0);
    tick();
    bus.rsv_en = 1'b0;
    bus.wr_en  = 1'b0;
    @(negedge clk);
    chk("mem_r3_p0", rdd(0), 32'h55);
    chk("mem_r3_p1", rdd(1), 32'h55);
    chk("mem_r3_pend", 32'(bus.rd_pend[0]), 32'd1);
    chk("mem_r3_pend1", 32'(bus.rd_pend[1]), 32'd1);

    // r0 is hardwired zero
    tick();
    wr(0, 32'hFFFFFFFF);
    set_rd(0, 5);
    @(negedge clk);
    chk("r0_byp", rdd(0), 32'h0);
    chk("r5_other", rdd(1), 32'hDEADBEEF);
    tick();
    bus.wr_en    = 1'b0;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 4'd0;
    @(negedge clk);
    chk("r0_mem", rdd(0), 32'h0);
    tick();
    bus.rsv_en = 1'b0;
    @(negedge clk);
    chk("r0_pend", 32'(bus.rd_pend[0]), 32'd0);

    // clear, restarted at sweep cycle 8 with a write
    tick();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (8) tick();
    bus.clr_req = 1'b1;
    wr(9, 32'hAB);
    set_rd(9, 9);
    @(negedge clk);
    chk("clr_busy", 32'(bus.busy), 32'd1);
    chk("clr_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("clr_rd", rdd(0), 32'h0);
    tick();
    bus.clr_req = 1'b0;
    bus.wr_en   = 1'b0;
    count_busy("clr_busy_len");
    read_all_zero("clr_zero");

    // reset in mid-operation
    tick();
    wr(2, 32'h77);
    tick();
    bus.wr_en = 1'b0;
    set_rd(2, 2);
    @(negedge clk);
    chk("mem_r2", rdd(0), 32'h77);
    tick();
    wr(4, 32'h99);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst2_wr_ready", 32'(bus.wr_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    bus.wr_en = 1'b0;
    count_busy("rst2_busy_len");
    read_all_zero("rst2_zero");

    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
